// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared types and constants for the router ingress arbiter.
//   state_t       : arbiter FSM states
//   ADDR_INVALID  : header address code that causes a packet drop
//   LEN_MSB/LSB   : position of the payload-length field in the header byte
//   DW, LEN_W     : byte width and length-field width
//   NUM_SRC       : number of packet sources (round-robin logic sized for 3)
// ---------------------------------------------------------------------------
package router_pkg;

   localparam int NUM_SRC = 3;
   localparam int DW      = 8;
   localparam int LEN_W   = 6;
   localparam int LEN_MSB = 7;
   localparam int LEN_LSB = 2;

   localparam logic [1:0] ADDR_INVALID = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PLD,
      PAR,
      DRAIN
   } state_t;

endpackage

// File: rtl/rr_arbiter3.sv
// ---------------------------------------------------------------------------
// rr_arbiter3
// Combinational 3-way round-robin picker.
//   req        : request vector, one bit per source
//   last_grant : index (0..2) of the source served most recently
//   winner     : one-hot winner, searching from last_grant+1 (mod 3);
//                all zero when nothing requests
// ---------------------------------------------------------------------------
module rr_arbiter3
   import router_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [1:0]         last_grant,
   output logic [NUM_SRC-1:0] winner
);

   always_comb begin
      winner = '0;
      case (last_grant)
         2'd0: begin
            if (req[1])      winner = 3'b010;
            else if (req[2]) winner = 3'b100;
            else if (req[0]) winner = 3'b001;
         end
         2'd1: begin
            if (req[2])      winner = 3'b100;
            else if (req[0]) winner = 3'b001;
            else if (req[1]) winner = 3'b010;
         end
         // 2 and the unused code 3 both restart the search at source 0
         default: begin
            if (req[0])      winner = 3'b001;
            else if (req[1]) winner = 3'b010;
            else if (req[2]) winner = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/router_in_arbiter.sv
// ---------------------------------------------------------------------------
// router_in_arbiter
// Ingress arbiter in front of router_top. Multiplexes three byte-stream
// packet sources onto one datain/packet_valid pair with packet-granular
// round-robin, honouring the router's busy back-pressure. Headers are parsed
// to find packet boundaries; invalid-address packets are dropped, packets
// whose source stalls mid-packet are aborted, and parity mismatches flagged.
// Packet: header {len[5:0], addr[1:0]}, len payload bytes, one parity byte.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high
//   src_valid[3] : per-source byte valid
//   src_data[24] : per-source byte, source i on [8i+7:8i]
//   src_ready[3] : per-source byte accept (combinational)
//   busy         : router_top back-pressure
//   datain[8]    : registered byte to router_top
//   packet_valid : registered packet framing to router_top
//   grant[3]     : one-hot current owner, 0 when idle
//   addr_err     : 1-cycle pulse, header with invalid address dropped
//   gap_err      : 1-cycle pulse, owner stalled mid-packet, packet aborted
//   par_err      : 1-cycle pulse, parity byte mismatch
// ---------------------------------------------------------------------------
module router_in_arbiter
   import router_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_SRC-1:0]    src_valid,
   input  logic [NUM_SRC*DW-1:0] src_data,
   output logic [NUM_SRC-1:0]    src_ready,
   input  logic                  busy,
   output logic [DW-1:0]         datain,
   output logic                  packet_valid,
   output logic [NUM_SRC-1:0]    grant,
   output logic                  addr_err,
   output logic                  gap_err,
   output logic                  par_err
);

   localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

   state_t             state;
   state_t             state_nxt;
   logic [1:0]         last_grant;
   logic [LEN_W:0]     cnt;
   logic [DW-1:0]      parity;
   logic [NUM_SRC-1:0] rr_winner;
   logic               sel_valid;
   logic [DW-1:0]      sel_byte;
   logic [LEN_W-1:0]   hdr_len;
   logic [1:0]         hdr_addr;
   logic               xfer;
   logic               gap;

   function automatic logic [1:0] grant_index(input logic [NUM_SRC-1:0] g);
      case (g)
         3'b010:  return 2'd1;
         3'b100:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   rr_arbiter3 u_rr (
      .req        (src_valid),
      .last_grant (last_grant),
      .winner     (rr_winner)
   );

   // Stage p0: select the owner's byte and decode the handshake
   always_comb begin
      sel_byte = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant[i]) sel_byte = src_data[i*DW +: DW];
      end
   end

   assign sel_valid = |(src_valid & grant);
   assign hdr_len   = sel_byte[LEN_MSB:LEN_LSB];
   assign hdr_addr  = sel_byte[LEN_LSB-1:0];

   // DRAIN discards bytes, so it keeps accepting even while the router is busy
   always_comb begin
      src_ready = '0;
      case (state)
         HDR, PLD, PAR: src_ready = grant & {NUM_SRC{~busy}};
         DRAIN:         src_ready = grant;
         default:       src_ready = '0;
      endcase
   end

   assign xfer = |(src_valid & src_ready);
   // A missing byte only counts as a gap once the header has been taken
   assign gap  = ((state == PLD) || (state == PAR)) && !busy && !sel_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (|src_valid) state_nxt = HDR;
         end
         HDR: begin
            if (xfer) begin
               if (hdr_addr == ADDR_INVALID) state_nxt = DRAIN;
               else if (hdr_len != '0)       state_nxt = PLD;
               else                          state_nxt = PAR;
            end
         end
         PLD: begin
            if (xfer) begin
               if (cnt == CNT_ONE) state_nxt = PAR;
            end else if (gap) begin
               state_nxt = DRAIN;
            end
         end
         PAR: begin
            if (xfer)     state_nxt = IDLE;
            else if (gap) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (xfer && (cnt == CNT_ONE)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p1: registered router-side outputs, grant, counter and parity
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         datain       <= '0;
         packet_valid <= 1'b0;
         grant        <= '0;
         last_grant   <= 2'd2;
         cnt          <= '0;
         parity       <= '0;
         addr_err     <= 1'b0;
         gap_err      <= 1'b0;
         par_err      <= 1'b0;
      end else begin
         addr_err <= 1'b0;
         gap_err  <= 1'b0;
         par_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (|src_valid) grant <= rr_winner;
            end
            HDR: begin
               if (xfer) begin
                  parity <= sel_byte;
                  if (hdr_addr == ADDR_INVALID) begin
                     // drop the whole packet: len payload bytes plus parity
                     cnt      <= {1'b0, hdr_len} + CNT_ONE;
                     addr_err <= 1'b1;
                  end else begin
                     cnt          <= {1'b0, hdr_len};
                     datain       <= sel_byte;
                     packet_valid <= 1'b1;
                  end
               end
            end
            PLD: begin
               if (xfer) begin
                  datain       <= sel_byte;
                  packet_valid <= 1'b1;
                  parity       <= parity ^ sel_byte;
                  cnt          <= cnt - CNT_ONE;
               end else if (gap) begin
                  // zero byte with packet_valid low ends the router packet early
                  datain       <= '0;
                  packet_valid <= 1'b0;
                  gap_err      <= 1'b1;
                  cnt          <= cnt + CNT_ONE;
               end
            end
            PAR: begin
               if (xfer) begin
                  datain       <= sel_byte;
                  packet_valid <= 1'b0;
                  par_err      <= (sel_byte != parity);
                  last_grant   <= grant_index(grant);
                  grant        <= '0;
               end else if (gap) begin
                  // cnt is already 0 here, leaving only the parity byte to drain
                  datain       <= '0;
                  packet_valid <= 1'b0;
                  gap_err      <= 1'b1;
                  cnt          <= cnt + CNT_ONE;
               end
            end
            DRAIN: begin
               if (xfer) begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     last_grant <= grant_index(grant);
                     grant      <= '0;
                  end
               end
            end
            default: begin
               grant <= '0;
            end
         endcase
      end
   end

endmodule
